// File: rtl/iterative_multiplier_wb_pkg.sv
// Shared encodings for the iterative LEGv8 multiplier: opcodes, FSM states
// and the zero-register index.
package iterative_multiplier_wb_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_SMULH = 2'b01,
        OP_UMULH = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/iterative_multiplier_wb_dp.sv
// Shift-add datapath: holds hi/lo/multiplicand and performs one radix-2
// iteration per enabled clock. Sequencing lives in the top level.
module mul_shift_add_dp #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_product
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;

    // The multiplier is shifted out of lo while product bits shift in above it.
    assign w_addend  = r_lo[0] ? r_mcand : '0;
    assign w_sum     = {1'b0, r_hi} + {1'b0, w_addend};
    assign o_product = {r_hi, r_lo};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
        end else if (i_load) begin
            r_hi    <= '0;
            r_lo    <= i_mplier;
            r_mcand <= i_mcand;
        end else if (i_step) begin
            r_hi <= w_sum[WIDTH:1];
            r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iterative_multiplier_wb.sv
// Multi-cycle 64x64 MUL/SMULH/UMULH unit that owns the register-file write
// port for its result and stalls the front end while busy.
module iterative_multiplier_wb
    import iterative_multiplier_wb_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [4:0]       Rd,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic             Abort,
    output logic             Stall,
    output logic [WIDTH-1:0] BusW,
    output logic [4:0]       RW,
    output logic             RegWr
);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    op_e              r_op;
    logic [4:0]       r_rd;
    logic             r_neg;
    logic [WIDTH-1:0] r_busw;
    logic [4:0]       r_rw;
    logic             r_regwr;

    logic               w_load;
    logic               w_step;
    logic               w_smulh;
    logic               w_neg;
    logic [WIDTH-1:0]   w_mcand;
    logic [WIDTH-1:0]   w_mplier;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH-1:0]   w_wb_data;

    // WB also accepts a new request so a held Start issues every 66 cycles.
    assign w_load = Start && !Abort && (r_state == ST_IDLE || r_state == ST_WB);
    assign w_step = (r_state == ST_RUN) && !Abort;

    // Magnitudes are unsigned, so |0x8000...0| = 2^63 is represented exactly.
    assign w_smulh  = (op_e'(Op) == OP_SMULH);
    assign w_neg    = w_smulh && (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
    assign w_mcand  = (w_smulh && BusA[WIDTH-1]) ? -BusA : BusA;
    assign w_mplier = (w_smulh && BusB[WIDTH-1]) ? -BusB : BusB;

    mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_mcand   (w_mcand),
        .i_mplier  (w_mplier),
        .o_product (w_prod)
    );

    assign w_res     = r_neg ? -w_prod : w_prod;
    assign w_wb_data = (r_op == OP_SMULH || r_op == OP_UMULH) ? w_res[2*WIDTH-1:WIDTH]
                                                              : w_res[WIDTH-1:0];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_MUL;
            r_rd    <= '0;
            r_neg   <= 1'b0;
            r_busw  <= '0;
            r_rw    <= '0;
            r_regwr <= 1'b0;
        end else if (Abort && r_state != ST_IDLE) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_regwr <= 1'b0;
        end else if (w_load) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_op    <= op_e'(Op);
            r_rd    <= Rd;
            r_neg   <= w_neg;
            r_regwr <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_busw  <= w_wb_data;
                    r_rw    <= r_rd;
                    r_regwr <= (r_rd != XZR);
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    r_regwr <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Stall = (r_state != ST_IDLE);
    assign BusW  = r_busw;
    assign RW    = r_rw;
    assign RegWr = r_regwr;

endmodule

// File: tb/tb_iterative_multiplier_wb.sv
// Directed bench for iterative_multiplier_wb: table of hand-computed products
// plus sequences for ignored Start, Abort, mid-run reset and back-to-back issue.
module tb_iterative_multiplier_wb;

    logic        Clk;
    logic        Rst_n;
    logic        Start;
    logic [1:0]  Op;
    logic [4:0]  Rd;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic        Abort;
    logic        Stall;
    logic [63:0] BusW;
    logic [4:0]  RW;
    logic        RegWr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vq[$];

    iterative_multiplier_wb #(.WIDTH(64), .CNT_W(7)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Start (Start),
        .Op    (Op),
        .Rd    (Rd),
        .BusA  (BusA),
        .BusB  (BusB),
        .Abort (Abort),
        .Stall (Stall),
        .BusW  (BusW),
        .RW    (RW),
        .RegWr (RegWr)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] rd, input logic [63:0] exp, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp; v.name = name;
        vq.push_back(v);
    endtask

    // Issues one request (edge k) and observes 68 cycles at negedges.
    // inject_idx: pulse a conflicting Start in that cycle; abort_idx: pulse Abort.
    task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic [63:0] exp,
                          input int inject_idx, input int abort_idx, input string name);
        int          stall_cnt;
        int          wr_cnt;
        int          wr_idx;
        int          exp_stall;
        int          exp_wr;
        logic [63:0] busw_at;
        logic [4:0]  rw_at;
        Op = op; BusA = a; BusB = b; Rd = rd; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        stall_cnt = 0; wr_cnt = 0; wr_idx = -1; busw_at = '0; rw_at = '0;
        for (int i = 0; i < 68; i++) begin
            @(negedge Clk);
            if (Stall) stall_cnt++;
            if (RegWr) begin
                wr_cnt++;
                wr_idx = i;
            end
            if (i == 65) begin
                busw_at = BusW;
                rw_at   = RW;
            end
            Start = (i == inject_idx);
            Abort = (i == abort_idx);
            if (i == inject_idx) begin
                Op = 2'b00; BusA = 64'd100; BusB = 64'd100; Rd = 5'd5;
            end
        end
        Start = 1'b0;
        Abort = 1'b0;
        exp_stall = (abort_idx >= 0) ? abort_idx + 1 : 66;
        exp_wr    = (abort_idx >= 0 || rd == 5'd31) ? 0 : 1;
        check($sformatf("%s stall_cycles", name), 64'(stall_cnt), 64'(exp_stall));
        check($sformatf("%s regwr_pulses", name), 64'(wr_cnt), 64'(exp_wr));
        if (exp_wr == 1)
            check($sformatf("%s regwr_cycle", name), 64'(wr_idx), 64'd65);
        if (abort_idx < 0) begin
            check($sformatf("%s busw", name), busw_at, exp);
            check($sformatf("%s rw", name), 64'(rw_at), 64'(rd));
        end
    endtask

    initial begin
        int p1, p2, npulse, drops, wait_cnt;
        int bad_wr, bad_stall;
        logic [63:0] busw_p2;

        Rst_n = 1'b0; Start = 1'b0; Abort = 1'b0; Op = '0; Rd = '0; BusA = '0; BusB = '0;
        #2;
        check("reset stall", 64'(Stall), 64'd0);
        check("reset regwr", 64'(RegWr), 64'd0);
        check("reset busw", BusW, 64'd0);
        check("reset rw", 64'(RW), 64'd0);
        #21 Rst_n = 1'b1;
        @(negedge Clk);

        add_vec(2'b00, 64'd3, 64'd5, 5'd2, 64'd15, "mul_3x5");
        add_vec(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3,
                64'hFFFF_FFFF_FFFF_FFFE, "umulh_max");
        add_vec(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 64'd1, "mul_max");
        add_vec(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, "smulh_m1x2");
        add_vec(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd7,
                64'h4000_0000_0000_0000, "smulh_minxmin");
        add_vec(2'b01, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'd0, "smulh_minxm1");
        add_vec(2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 5'd9,
                64'h3FFF_FFFF_FFFF_FFFF, "smulh_maxpos");
        add_vec(2'b01, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, "smulh_3xm5");
        add_vec(2'b00, 64'd0, 64'd0, 5'd11, 64'd0, "mul_zero");
        add_vec(2'b11, 64'd6, 64'd7, 5'd12, 64'd42, "rsvd_6x7");
        add_vec(2'b10, 64'h8000_0000_0000_0000, 64'd4, 5'd13, 64'd2, "umulh_2p63x4");
        add_vec(2'b10, 64'd3, 64'd5, 5'd14, 64'd0, "umulh_small");
        add_vec(2'b00, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 5'd0,
                64'h0000_0002_0000_0001, "mul_carry");
        add_vec(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd30, 64'hFFFF_FFFF_FFFF_FFFE, "mul_m1x2");

        foreach (vq[i])
            run_op(vq[i].op, vq[i].a, vq[i].b, vq[i].rd, vq[i].exp, -1, -1, vq[i].name);

        // XZR destination with a conflicting Start mid-run
        run_op(2'b00, 64'd7, 64'd9, 5'd31, 64'd63, 9, -1, "xzr_ignored_start");
        run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17,
               64'hFFFF_FFFF_FFFF_FFFE, 9, -1, "ignored_start_umulh");

        // Abort at edge k+30
        run_op(2'b00, 64'd3, 64'd5, 5'd2, 64'd15, -1, 29, "abort");

        // Reset asserted mid-clock during a run
        Op = 2'b00; BusA = 64'h1234; BusB = 64'd2; Rd = 5'd4; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        repeat (41) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("midreset stall", 64'(Stall), 64'd0);
        check("midreset regwr", 64'(RegWr), 64'd0);
        check("midreset busw", BusW, 64'd0);
        check("midreset rw", 64'(RW), 64'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        bad_wr = 0; bad_stall = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge Clk);
            if (RegWr) bad_wr++;
            if (Stall) bad_stall++;
        end
        check("postreset regwr_pulses", 64'(bad_wr), 64'd0);
        check("postreset stall_cycles", 64'(bad_stall), 64'd0);
        run_op(2'b00, 64'd3, 64'd5, 5'd2, 64'd15, -1, -1, "postreset_mul");

        // Back-to-back with Start held high
        Op = 2'b00; BusA = 64'd3; BusB = 64'd5; Rd = 5'd2; Start = 1'b1;
        @(posedge Clk);
        p1 = -1; p2 = -1; npulse = 0; drops = 0; busw_p2 = '0;
        for (int i = 0; i < 140; i++) begin
            @(negedge Clk);
            if (!Stall) drops++;
            if (RegWr) begin
                npulse++;
                if (p1 < 0) p1 = i;
                else if (p2 < 0) begin
                    p2 = i;
                    busw_p2 = BusW;
                end
            end
        end
        Start = 1'b0;
        check("b2b first_pulse", 64'(p1), 64'd65);
        check("b2b pulse_spacing", 64'(p2 - p1), 64'd66);
        check("b2b pulse_count", 64'(npulse), 64'd2);
        check("b2b stall_drops", 64'(drops), 64'd0);
        check("b2b busw", busw_p2, 64'd15);
        wait_cnt = 0;
        while (Stall && wait_cnt < 100) begin
            @(negedge Clk);
            wait_cnt++;
        end
        check("b2b drains", 64'(Stall), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
